// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register block, TX byte FIFO and serialiser.
// Registers sit at BASE_ADDR + {0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL}.
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F100,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        txd_o,
    output logic        tx_irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [15:0]   baud_q;
    logic          tx_en_q, irq_en_q;

    logic          hit, wr, full, empty, push_req, push, pop, busy, start_frame;
    logic [1:0]    sel;
    logic [31:0]   count_ext;
    logic [3:0]    fill;
    logic          unused_bits;

    assign hit      = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign sel      = addr_i[3:2];
    assign wr       = hit & wen_i;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr & (sel == 2'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req & (~full | pop);
    assign busy     = (state_q != StIdle);
    assign tx_irq_o = irq_en_q & empty & ~busy;
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (push_req && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (wr && sel == 2'd1 && wdata_i[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            baud_q   <= DIV_RESET;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
        end else if (wr) begin
            if (sel == 2'd2) baud_q <= (wdata_i[15:0] < 16'd2) ? 16'd2 : wdata_i[15:0];
            if (sel == 2'd3) {irq_en_q, tx_en_q} <= wdata_i[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        txd_o       = 1'b1;
        unique case (state_q)
            StIdle: begin
                start_frame = tx_en_q & ~empty;
            end
            StStart: begin
                txd_o = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = period_q;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                txd_o = shift_q[0];
                if (cnt_q == '0) begin
                    cnt_d     = period_q;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    start_frame = tx_en_q & ~empty;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // BAUDDIV is latched per frame so mid-frame writes only affect the next one.
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = mem[rptr_q];
            period_d  = baud_q;
            cnt_d     = baud_q;
            bit_idx_d = '0;
            state_d   = StStart;
        end
    end

    assign count_ext = 32'(count_q);
    assign fill      = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        rdata_o = '0;
        if (hit) begin
            case (sel)
                2'd1:    rdata_o = {24'b0, fill, overflow_q, busy, empty, full};
                2'd2:    rdata_o = {16'b0, baud_q};
                2'd3:    rdata_o = {30'b0, irq_en_q, tx_en_q};
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed scenarios plus randomized bursts
// checked against a queue-based model and an ideal 8N1 waveform.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_F100;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_BD  = BASE + 32'h8;
    localparam logic [31:0] A_CT  = BASE + 32'hC;
    localparam int          DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        wen_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        txd_o;
    logic        tx_irq_o;

    int n_checks = 0;
    int n_errors = 0;
    int irq_seen = 0;

    bus_uart_tx dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .wen_i    (wen_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .txd_o    (txd_o),
        .tx_irq_o (tx_irq_o)
    );

    always #50 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the write commits on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        wen_i   = 1'b1;
        @(negedge clk_i);
        wen_i   = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        wen_i  = 1'b0;
        #1;
        d = rdata_o;
        addr_i = '0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_read(a, r);
        check(tag, r, exp);
    endtask

    // waited = number of falling edges until the start bit was seen (0 = already low).
    // Returns on the falling edge of the last stop-bit cycle.
    task automatic expect_frame(input logic [7:0] b, input int p, output int waited);
        logic [9:0] fr;
        logic [7:0] got;
        int errs;
        fr = {1'b1, b, 1'b0};
        got = '0;
        errs = 0;
        waited = 0;
        while (txd_o !== 1'b0 && waited < 400) begin
            @(negedge clk_i);
            waited++;
        end
        if (txd_o !== 1'b0) begin
            check("frame_start", {31'b0, txd_o}, 32'd0);
            return;
        end
        for (int k = 0; k < 10 * p; k++) begin
            if (k > 0) @(negedge clk_i);
            if (txd_o !== fr[k / p]) errs++;
            if ((k % p) == (p / 2) && (k / p) >= 1 && (k / p) <= 8) got[k / p - 1] = txd_o;
            if (tx_irq_o === 1'b1) irq_seen++;
        end
        check("frame_wave", errs, 0);
        check("frame_byte", {24'b0, got}, {24'b0, b});
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (txd_o !== 1'b1) lows++;
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [7:0]  ov_bytes [9];
        logic [7:0]  b;
        logic [7:0]  q [$];
        logic        ovf;
        int          w, lows, v, k, p;

        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reg("rst_status", A_ST, 32'h2);
        check_reg("rst_baud", A_BD, 32'd433);
        check_reg("rst_ctrl", A_CT, 32'h1);
        check_reg("rst_txdata", A_TX, 32'h0);
        check_reg("miss_read", BASE + 32'h20, 32'h0);
        check("rst_txd", {31'b0, txd_o}, 32'd1);
        check("rst_irq", {31'b0, tx_irq_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reg("post_rst_status", A_ST, 32'h2);

        // Single frame, bit period 4
        bus_write(A_BD, 32'd3);
        check_reg("baud3", A_BD | 32'h1, 32'd3);
        bus_write(A_TX, 32'hA5);
        expect_frame(8'hA5, 4, w);
        check("a5_latency", w, 1);
        check_reg("a5_busy_last", A_ST, 32'h6);
        @(negedge clk_i);
        check_reg("a5_idle", A_ST, 32'h2);

        // Back-to-back frames, bit period 3
        bus_write(A_BD, 32'd2);
        bus_write(A_CT, 32'd0);
        bus_write(A_TX, 32'h01);
        bus_write(A_TX, 32'h80);
        check_reg("b2b_count2", A_ST, 32'h20);
        bus_write(A_CT, 32'd1);
        expect_frame(8'h01, 3, w);
        check("b2b_latency", w, 1);
        check_reg("b2b_count1", A_ST, 32'h14);
        expect_frame(8'h80, 3, w);
        check("b2b_gap", w, 1);
        check_reg("b2b_count0", A_ST, 32'h6);
        @(negedge clk_i);
        check_reg("b2b_idle", A_ST, 32'h2);

        // Overflow with transmitter disabled
        bus_write(A_CT, 32'd0);
        lows = 0;
        for (int i = 0; i < 9; i++) begin
            ov_bytes[i] = 8'(i * 37 + 5);
            bus_write(A_TX, {24'b0, ov_bytes[i]});
            if (txd_o !== 1'b1) lows++;
        end
        check("ovf_quiet", lows, 0);
        check_reg("ovf_status", A_ST, 32'h89);
        bus_write(A_ST, 32'h8);
        check_reg("ovf_cleared", A_ST, 32'h81);
        bus_write(A_CT, 32'd1);
        for (int i = 0; i < 8; i++) expect_frame(ov_bytes[i], 3, w);
        count_lows(60, lows);
        check("ovf_no_ninth", lows, 0);
        check_reg("ovf_drained", A_ST, 32'h2);

        // BAUDDIV written in the same cycle the frame loads
        bus_write(A_CT, 32'd0);
        bus_write(A_TX, 32'h3C);
        bus_write(A_TX, 32'hC3);
        bus_write(A_CT, 32'd1);
        bus_write(A_BD, 32'd5);
        expect_frame(8'h3C, 3, w);
        check("baudchg_first", w, 0);
        expect_frame(8'hC3, 6, w);
        check("baudchg_second", w, 1);
        @(negedge clk_i);

        // tx_en cleared mid-frame: frame completes, rest stays queued
        bus_write(A_BD, 32'd2);
        bus_write(A_CT, 32'd0);
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_CT, 32'd1);
        bus_write(A_CT, 32'd0);
        expect_frame(8'h11, 3, w);
        count_lows(40, lows);
        check("txen_off_quiet", lows, 0);
        check_reg("txen_off_kept", A_ST, 32'h10);
        bus_write(A_CT, 32'd1);
        expect_frame(8'h22, 3, w);
        @(negedge clk_i);

        // Interrupt
        bus_write(A_CT, 32'd3);
        check("irq_idle", {31'b0, tx_irq_o}, 32'd1);
        bus_write(A_TX, 32'h5A);
        check("irq_pending", {31'b0, tx_irq_o}, 32'd0);
        irq_seen = 0;
        expect_frame(8'h5A, 3, w);
        check("irq_busy", irq_seen, 0);
        @(negedge clk_i);
        check("irq_rise", {31'b0, tx_irq_o}, 32'd1);
        bus_write(A_CT, 32'd1);

        // Randomized bursts against the queue model
        for (int it = 0; it < 6; it++) begin
            v = $urandom_range(0, 6);
            r = $urandom;
            bus_write(A_BD, {r[31:16], 16'(v)});
            p = ((v < 2) ? 2 : v) + 1;
            check_reg("rnd_baud", A_BD, 32'(p - 1));
            bus_write(A_CT, 32'd0);
            k = $urandom_range(1, 11);
            q.delete();
            ovf = 1'b0;
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                bus_write(A_TX | 32'($urandom_range(0, 3)), {24'($urandom), b});
                if (q.size() < DEPTH) q.push_back(b);
                else ovf = 1'b1;
                a = BASE ^ (32'h1 << $urandom_range(4, 31));
                bus_write(a, $urandom);
            end
            check_reg("rnd_status", A_ST, {24'b0, 4'(q.size()), ovf, 1'b0,
                                            q.size() == 0, q.size() == DEPTH});
            if (ovf) begin
                bus_write(A_ST, 32'hFFFF_FFF8);
                check_reg("rnd_ovf_clr", A_ST, {24'b0, 4'(q.size()), 2'b00,
                                                 q.size() == 0, q.size() == DEPTH});
            end
            bus_write(A_CT, 32'd1);
            while (q.size() > 0) begin
                b = q.pop_front();
                expect_frame(b, p, w);
                check("rnd_gap", w, 1);
            end
            @(negedge clk_i);
            check_reg("rnd_idle", A_ST, 32'h2);
        end

        // Reset in the middle of a data bit
        bus_write(A_BD, 32'd3);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h00);
        repeat (8) @(negedge clk_i);
        check("pre_rst_data", {31'b0, txd_o}, 32'd0);
        #10;
        rst_i = 1'b0;
        #1;
        check("rst_async_txd", {31'b0, txd_o}, 32'd1);
        check_reg("rst_mid_status", A_ST, 32'h2);
        check_reg("rst_mid_baud", A_BD, 32'd433);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reg("rst_rel_status", A_ST, 32'h2);
        count_lows(40, lows);
        check("rst_fifo_lost", lows, 0);
        bus_write(A_BD, 32'd2);
        check_reg("baud_w2", A_BD, 32'd2);
        bus_write(A_BD, 32'd0);
        check_reg("baud_w0", A_BD, 32'd2);
        bus_write(A_BD, 32'd1);
        check_reg("baud_w1", A_BD, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
